// File: rtl/sic_dispatch_pkg.sv
// Shared types for the sub-SIC dispatch path: the sic_packet_t payload and width helpers.
package sic_dispatch_pkg;

    localparam int unsigned SicNumPhyRegs = 64;
    localparam int unsigned SicNumEcrs    = 4;
    localparam int unsigned SicIdWidth    = 4;

    localparam int unsigned SicPhyRegW = $clog2(SicNumPhyRegs);
    localparam int unsigned SicEcrW    = $clog2(SicNumEcrs);

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [SicPhyRegW-1:0] rd;
        logic [SicPhyRegW-1:0] rs1;
        logic [SicPhyRegW-1:0] rs2;
        logic [SicEcrW-1:0]    ecr;
        logic [SicIdWidth-1:0] id;
    } sic_packet_t;

    // Occupancy counters need one more bit than the pointers to represent "full".
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sic_dispatch_if.sv
// Issue-side bundle between the issue stage, the dispatch FIFO and the sub-SIC slots.
interface sic_dispatch_if #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    import sic_dispatch_pkg::*;

    sic_packet_t                             up_pkt;
    logic                                    up_ready;
    logic                                    flush;
    logic [NUM_SLOTS-1:0]                    slot_req;
    sic_packet_t [NUM_SLOTS-1:0]             slot_pkt;
    logic [cnt_width(FIFO_DEPTH)-1:0]        fifo_count;

    modport master (
        output up_pkt,
        output flush,
        output slot_req,
        input  up_ready,
        input  slot_pkt,
        input  fifo_count
    );

    modport slave (
        input  up_pkt,
        input  flush,
        input  slot_req,
        output up_ready,
        output slot_pkt,
        output fifo_count
    );

endinterface

// File: rtl/sic_dispatch_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i, wrapping.
module sic_dispatch_rr_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    int unsigned cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr_i) + off) % N;
            if (!any_o && eligible_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/sic_dispatch.sv
// Buffers issue packets and hands each to one requesting sub-SIC slot, round-robin.
// Optional stall_cycles counter enabled by defining SIC_DISPATCH_STALL_CNT_EN.
module sic_dispatch
    import sic_dispatch_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned NUM_PHY_REGS = 64,
    parameter int unsigned NUM_ECRS     = 4,
    parameter int unsigned ID_WIDTH     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SIC_DISPATCH_STALL_CNT_EN
    output logic [31:0]  stall_cycles,
`endif
    sic_dispatch_if.slave bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
    localparam int unsigned SelW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // The packet layout is fixed in the package; reject mismatched overrides.
    if (NUM_PHY_REGS != SicNumPhyRegs || NUM_ECRS != SicNumEcrs || ID_WIDTH != SicIdWidth ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NUM_SLOTS < 1) begin : g_bad_cfg
        $error("sic_dispatch: unsupported parameter combination");
    end

    sic_packet_t                 mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]             count_q, count_d;
    logic [SelW-1:0]             rr_ptr_q, rr_ptr_d;
    sic_packet_t [NUM_SLOTS-1:0] slot_pkt_q, slot_pkt_d;

    logic [NUM_SLOTS-1:0] eligible, grant;
    logic [SelW-1:0]      sel_idx;
    logic                 any_elig, not_empty, push, pop;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            eligible[i] = bus.slot_req[i] && !slot_pkt_q[i].valid;
        end
    end

    sic_dispatch_rr_arb #(
        .N    (NUM_SLOTS),
        .IdxW (SelW)
    ) u_rr_arb (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .idx_o      (sel_idx),
        .any_o      (any_elig)
    );

    assign not_empty    = (count_q != '0);
    assign bus.up_ready = rst_n && !bus.flush && (count_q < CntW'(FIFO_DEPTH));
    assign push         = bus.up_pkt.valid && bus.up_ready;
    assign pop          = !bus.flush && not_empty && any_elig;

    assign bus.slot_pkt   = slot_pkt_q;
    assign bus.fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            rr_ptr_d = (sel_idx == SelW'(NUM_SLOTS - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    // Valid is a single-cycle pulse; payloads of idle slots are simply held.
    always_comb begin
        slot_pkt_d = slot_pkt_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_pkt_d[i].valid = 1'b0;
            if (pop && grant[i]) begin
                slot_pkt_d[i]       = mem_q[rd_ptr_q];
                slot_pkt_d[i].valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.up_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            slot_pkt_q <= '0;
        end else begin
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            slot_pkt_q <= slot_pkt_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef SIC_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (not_empty && !bus.flush && !any_elig && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/sic_dispatch.md
Name: sic_dispatch

Overview:
- Issue-side counterpart of the sub-SIC packet interface.
- Buffers packets from the issue stage in a small FIFO.
- Delivers each packet to exactly one sub-SIC slot whose `req_instr` is asserted; one delivery per cycle, round-robin among requesting slots.
- Every output is registered, so there is no combinational path from `req_instr` to `pkt.valid`. This matters because a sub-SIC drops `req_instr` combinationally while its `pkt.valid` is high.

Parameters:
- NUM_SLOTS, 4, number of sub-SIC slots served (≥1)
- FIFO_DEPTH, 4, packet buffer entries (power of two, ≥2)
- NUM_PHY_REGS, 64, forwarded to the `sic_packet` type
- NUM_ECRS, 4, forwarded to the `sic_packet` type
- ID_WIDTH, 4, forwarded to the `sic_packet` type

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- up_pkt  in  sic_packet_t  packet from issue; offered when `up_pkt.valid` is high
- up_ready  out  1  FIFO can accept this cycle
- flush  in  1  mispredict flush; drop everything buffered and in flight
- slot_req  in  NUM_SLOTS  `req_instr` from each sub-SIC
- slot_pkt  out  NUM_SLOTS x sic_packet_t  packet driven into each sub-SIC's `in.pkt`
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - FIFO empty; `fifo_count`=0.
  - Every `slot_pkt` is all-zero, including `.valid`=0.
  - Round-robin pointer = 0.
  - `up_ready` = 0 while `rst_n` is low.
- `up_ready` is combinational: `= !flush && (fifo_count < FIFO_DEPTH)`. There is no same-cycle pop-to-push bypass.
- Push: on a clock edge with `up_pkt.valid && up_ready`, the packet is written at the tail.
- Dispatch decision at each edge, using the current-cycle `slot_req`, the FIFO head and the pointer:
  - eligible[i] = `slot_req[i] && !slot_pkt[i].valid`.
  - If the FIFO is non-empty, no flush, and any slot is eligible, choose the first eligible slot at or after the pointer (wrapping modulo NUM_SLOTS).
  - `slot_pkt[sel]` ← head, with `.valid`=1; pop the head; pointer ← (sel+1) mod NUM_SLOTS.
- Each `slot_pkt[i].valid` is a one-cycle pulse. Every slot not selected at an edge has its `.valid` cleared at that edge (payload may be held; only `.valid` is defined).
- Latency:
  - A packet pushed at edge k can appear on `slot_pkt` after edge k+1 at the earliest.
  - Push and pop at the same edge are allowed; the count is unchanged.
- Only the head is ever dispatched (in-order). At most one pop per cycle.
- Empty FIFO: no dispatch; the pointer holds.
- Full FIFO: `up_ready`=0 and the upstream holds its packet.
- Wrap-around: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. `fifo_count` is tracked separately.
- flush=1 at an edge:
  - FIFO emptied.
  - All `slot_pkt.valid` ← 0, including a pulse that would otherwise have been issued.
  - No push and no pop; the pointer holds.
  - Flush has priority over everything except reset.
- An all-zero `slot_req` never pops.
- A slot holding `req` high continuously is served at most once every two cycles, because of the `!slot_pkt[i].valid` term.

Optional Feature:
- Macro: SIC_DISPATCH_STALL_CNT_EN.
- When defined:
  - Extra output `stall_cycles` [31:0], reset 0.
  - Increments at each edge where the FIFO is non-empty, flush=0 and no slot is eligible.
  - Saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- `sic_packet` / `sic_packet_t` stay in the shared `structs.svh`.
- A package-level localparam helper for the count width, ($clog2(FIFO_DEPTH)+1), goes there too.
- One sub-module: `sic_dispatch_rr_arb`.
  - Combinational round-robin pick from an eligible vector and a pointer.
  - Outputs a one-hot grant plus an index; it is reusable by other issue arbiters.
- The FIFO is inline.

Test Plan:
- Reset mid-operation: 3 packets buffered, pulse `rst_n` low → `fifo_count`=0 and all `.valid`=0 immediately, with no clock needed; nothing is dispatched after release.
- Single slot: `slot_req`=4'b0001, push pc=0x100, 0x104 on consecutive edges → `slot_pkt[0]` carries 0x100 valid one cycle after push, then 0x104 two cycles later. Never two consecutive valid cycles.
- Round-robin: `slot_req`=4'b1111 held, 4 packets preloaded → dispatched to slots 0,1,2,3 in order with pcs in FIFO order; pointer returns to 0.
- Full/backpressure: `slot_req`=0, push 5 packets → `up_ready`=0 after the 4th; the 5th is held. Raise `slot_req[2]` → a pop occurs, and the 5th is accepted on the following edge.
- Flush: FIFO holds 3 and `slot_pkt[1].valid` would fire → assert flush one cycle → `fifo_count`=0, no valid pulse, and an `up_pkt` offered that cycle is dropped (`up_ready`=0).
- With SIC_DISPATCH_STALL_CNT_EN: 2 packets buffered, `slot_req`=0 for 10 cycles → `stall_cycles`=10. It stays 10 after the FIFO drains.
